llt_phase_loader: RTL and testbench

Sequencer that fills the lease lookup table at every phase change. On `start_i` it fetches the phase's reference-address words and lease words from a memory region, one word at a time, over a single-outstanding read port. It drives the table's write port (`addr`/`wren`/`data`/`phase_refs`). Table slots beyond the phase's reference count are overwritten with zero so their valid bits clear. It sits between the phase-detect/control logic and the lease lookup table inside the cache.

---
 rtl/lease_cache_pkg.sv | 24 ++
 rtl/llt_phase_loader.sv | 150 +++++++++++++++
 tb/tb_llt_phase_loader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lease_cache_pkg.sv
// Shared definitions for the lease cache: loader state encoding, CLOG2 helper
// and the lookup-table array selects.
package lease_cache_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_REQ   = 3'd1,
        LDR_WAIT  = 3'd2,
        LDR_WRITE = 3'd3,
        LDR_FILL  = 3'd4,
        LDR_DONE  = 3'd5
    } loader_state_e;

    localparam logic ARR_REF   = 1'b0;
    localparam logic ARR_LEASE = 1'b1;

    function automatic int CLOG2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/llt_phase_loader.sv
// Fills the lease lookup table from a phase record in memory: reference words,
// zero fill of unused reference slots, then lease words. All outputs registered.
module llt_phase_loader
    import lease_cache_pkg::*;
#(
    parameter  int N_ENTRIES  = 128,
    localparam int BW_ENTRIES = CLOG2(N_ENTRIES)
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic [31:0]           base_addr_i,
    input  logic [BW_ENTRIES-1:0] n_refs_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [BW_ENTRIES:0]   tbl_addr_o,
    output logic                  tbl_wren_o,
    output logic [31:0]           tbl_data_o,
    output logic [BW_ENTRIES-1:0] tbl_phase_refs_o
);

    localparam logic [BW_ENTRIES-1:0] IDX_MAX = BW_ENTRIES'(N_ENTRIES - 1);

    loader_state_e         state_q, state_d;
    logic [31:0]           base_q, base_d;
    logic [BW_ENTRIES-1:0] n_refs_q, n_refs_d;
    logic                  pass_q, pass_d;
    logic [BW_ENTRIES-1:0] idx_q, idx_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_req_q, mem_req_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [BW_ENTRIES:0]   tbl_addr_q, tbl_addr_d;
    logic                  tbl_wren_q, tbl_wren_d;
    logic [31:0]           tbl_data_q, tbl_data_d;

    logic                  idx_last;
    logic [31:0]           word_idx;

    assign idx_last = ((BW_ENTRIES+1)'(idx_q) + (BW_ENTRIES+1)'(1)) == (BW_ENTRIES+1)'(n_refs_q);

    always_ff @(posedge clock_i) begin
        // NOTE: registers use <= so every flop samples the pre-edge values.
        if (!resetn_i) begin
            state_q    <= LDR_IDLE;
            base_q     <= '0;
            n_refs_q   <= '0;
            pass_q     <= ARR_REF;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            tbl_addr_q <= '0;
            tbl_wren_q <= 1'b0;
            tbl_data_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_refs_q   <= n_refs_d;
            pass_q     <= pass_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            tbl_addr_q <= tbl_addr_d;
            tbl_wren_q <= tbl_wren_d;
            tbl_data_q <= tbl_data_d;
        end
    end

    always_comb begin
        // NOTE: every *_d starts at its held value so no branch can infer a latch.
        state_d  = state_q;
        base_d   = base_q;
        n_refs_d = n_refs_q;
        pass_d   = pass_q;
        idx_d    = idx_q;
        case (state_q)
            LDR_IDLE: begin
                if (start_i) begin
                    base_d   = base_addr_i & ~32'h3;
                    n_refs_d = n_refs_i;
                    pass_d   = ARR_REF;
                    idx_d    = '0;
                    state_d  = (n_refs_i != '0) ? LDR_REQ : LDR_FILL;
                end
            end
            LDR_REQ:  if (mem_ready_i)  state_d = LDR_WAIT;
            LDR_WAIT: if (mem_rvalid_i) state_d = LDR_WRITE;
            LDR_WRITE: begin
                idx_d = idx_q + BW_ENTRIES'(1);
                if (!idx_last)              state_d = LDR_REQ;
                else if (pass_q == ARR_REF) state_d = LDR_FILL;
                else                        state_d = LDR_DONE;
            end
            LDR_FILL: begin
                if (idx_q == IDX_MAX) begin
                    pass_d  = ARR_LEASE;
                    idx_d   = '0;
                    state_d = (n_refs_q != '0) ? LDR_REQ : LDR_DONE;
                end else begin
                    idx_d = idx_q + BW_ENTRIES'(1);
                end
            end
            LDR_DONE: state_d = LDR_IDLE;
            default:  state_d = LDR_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they describe.
    always_comb begin
        busy_d     = (state_d != LDR_IDLE);
        done_d     = (state_d == LDR_DONE);
        mem_req_d  = (state_d == LDR_REQ);
        mem_addr_d = mem_addr_q;
        tbl_wren_d = 1'b0;
        tbl_addr_d = tbl_addr_q;
        tbl_data_d = tbl_data_q;
        word_idx   = 32'(idx_d) + ((pass_d == ARR_LEASE) ? 32'(N_ENTRIES) : 32'd0);
        if (state_d == LDR_REQ) mem_addr_d = base_d + (word_idx << 2);
        if (state_d == LDR_WRITE) begin
            tbl_wren_d = 1'b1;
            tbl_addr_d = {pass_d, idx_d};
            tbl_data_d = mem_rdata_i;
        end else if (state_d == LDR_FILL) begin
            tbl_wren_d = 1'b1;
            tbl_addr_d = {ARR_REF, idx_d};
            tbl_data_d = '0;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign mem_req_o        = mem_req_q;
    assign mem_addr_o       = mem_addr_q;
    assign tbl_addr_o       = tbl_addr_q;
    assign tbl_wren_o       = tbl_wren_q;
    assign tbl_data_o       = tbl_data_q;
    assign tbl_phase_refs_o = n_refs_q;

endmodule

// File: tb/tb_llt_phase_loader.sv
// Directed bench for llt_phase_loader with an 8-entry table and a cycle-stepped
// memory responder (ready by default, rvalid one cycle after acceptance).
module tb_llt_phase_loader;

    localparam int N  = 8;
    localparam int BW = 3;

    logic          clk;
    logic          resetn_i;
    logic          start_i;
    logic [31:0]   base_addr_i;
    logic [BW-1:0] n_refs_i;
    logic          busy_o, done_o, mem_req_o;
    logic [31:0]   mem_addr_o;
    logic          mem_ready_i, mem_rvalid_i;
    logic [31:0]   mem_rdata_i;
    logic [BW:0]   tbl_addr_o;
    logic          tbl_wren_o;
    logic [31:0]   tbl_data_o;
    logic [BW-1:0] tbl_phase_refs_o;

    llt_phase_loader #(.N_ENTRIES(N)) dut (
        .clock_i(clk), .resetn_i(resetn_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .n_refs_i(n_refs_i),
        .busy_o(busy_o), .done_o(done_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .tbl_addr_o(tbl_addr_o), .tbl_wren_o(tbl_wren_o), .tbl_data_o(tbl_data_o),
        .tbl_phase_refs_o(tbl_phase_refs_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total, bad;
    int cyc, done_cyc, done_cnt, addr_unstable, refs_glitch;
    int req_num, stall_req, stall_left, spur_req, mid_start_cyc;
    logic spur_arm, prev_req, resp_pending;
    logic [31:0] prev_addr, resp_data;
    logic [BW-1:0] cur_refs;
    logic [31:0] rd_q[$], exp_rd[$], wd_q[$], exp_wd[$], stall_addr_q[$];
    logic [BW:0] wa_q[$], exp_wa[$];

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'h5A00_00C3;
    endfunction

    task automatic default_knobs();
        stall_req = 0; stall_left = 0; spur_req = 0; spur_arm = 1'b0; mid_start_cyc = -1;
    endtask

    task automatic build_expected(input logic [31:0] base, input int n);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int i = 0; i < n; i++) exp_rd.push_back(base + 32'(4 * i));
        for (int i = 0; i < n; i++) exp_rd.push_back(base + 32'(4 * (N + i)));
        for (int i = 0; i < N; i++) begin
            exp_wa.push_back(4'(i));
            exp_wd.push_back((i < n) ? mem_data(base + 32'(4 * i)) : 32'h0);
        end
        for (int i = 0; i < n; i++) begin
            exp_wa.push_back(4'(N + i));
            exp_wd.push_back(mem_data(base + 32'(4 * (N + i))));
        end
    endtask

    // One cycle: drive responder inputs, record DUT activity, advance to next negedge.
    task automatic tick();
        mem_rvalid_i = resp_pending;
        mem_rdata_i  = resp_pending ? resp_data : 32'h0;
        resp_pending = 1'b0;
        mem_ready_i  = 1'b1;
        if (cyc == mid_start_cyc) begin
            start_i  = 1'b1;
            n_refs_i = 3'd5;
        end else begin
            start_i = 1'b0;
        end
        if (mem_req_o && !prev_req) req_num++;
        if (mem_req_o && req_num == stall_req && stall_left > 0) begin
            mem_ready_i = 1'b0;
            stall_left--;
            stall_addr_q.push_back(mem_addr_o);
        end else if (mem_req_o && req_num == spur_req && spur_arm) begin
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
            spur_arm     = 1'b0;
        end
        if (mem_req_o && prev_req && mem_addr_o !== prev_addr) addr_unstable++;
        prev_req  = mem_req_o;
        prev_addr = mem_addr_o;
        if (mem_req_o && mem_ready_i) begin
            rd_q.push_back(mem_addr_o);
            resp_pending = 1'b1;
            resp_data    = mem_data(mem_addr_o);
        end
        if (tbl_wren_o) begin
            wa_q.push_back(tbl_addr_o);
            wd_q.push_back(tbl_data_o);
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o && tbl_phase_refs_o !== cur_refs) refs_glitch++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic begin_load(input logic [31:0] base, input logic [BW-1:0] n);
        rd_q.delete(); wa_q.delete(); wd_q.delete(); stall_addr_q.delete();
        done_cnt = 0; done_cyc = -1; addr_unstable = 0; refs_glitch = 0; req_num = 0;
        prev_req = 1'b0; prev_addr = '0; resp_pending = 1'b0; cur_refs = n;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        base_addr_i = base; n_refs_i = n; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
    endtask

    task automatic finish_load(input string name, input int budget);
        while (done_cnt == 0 && cyc <= budget) tick();
        total++;
        if (done_cnt == 0) begin
            bad++;
            $display("FAIL %s_timeout got=no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        resetn_i = 1'b0; start_i = 1'b0; base_addr_i = '0; n_refs_i = '0;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        total += 4;
        if ({busy_o, done_o, mem_req_o, tbl_wren_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=0000", {busy_o, done_o, mem_req_o, tbl_wren_o});
        end
        if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
        if (tbl_addr_o !== 4'h0 || tbl_data_o !== 32'h0) begin
            bad++; $display("FAIL reset_tbl got=%h/%h exp=0/0", tbl_addr_o, tbl_data_o);
        end
        if (tbl_phase_refs_o !== 3'd0) begin bad++; $display("FAIL reset_refs got=%0d exp=0", tbl_phase_refs_o); end
        resetn_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] hand_rd [6];
        hand_rd = '{32'h1000, 32'h1004, 32'h1008, 32'h1020, 32'h1024, 32'h1028};
        default_knobs();
        build_expected(32'h1000, 3);
        begin_load(32'h1000, 3'd3);
        finish_load("basic", 200);
        total++;
        if (rd_q.size() != 6) begin bad++; $display("FAIL basic_rd_count got=%0d exp=6", rd_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            total++;
            if (rd_q[i] !== hand_rd[i]) begin bad++; $display("FAIL basic_rd[%0d] got=%h exp=%h", i, rd_q[i], hand_rd[i]); end
        end
        total++;
        if (wa_q.size() != exp_wa.size()) begin bad++; $display("FAIL basic_wr_count got=%0d exp=%0d", wa_q.size(), exp_wa.size()); end
        else foreach (exp_wa[i]) begin
            total++;
            if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
                bad++; $display("FAIL basic_wr[%0d] got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        total += 4;
        if (done_cyc !== 24) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=24", done_cyc); end
        if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy_o); end
        if (tbl_phase_refs_o !== 3'd3) begin bad++; $display("FAIL basic_refs_after got=%0d exp=3", tbl_phase_refs_o); end
    endtask

    task automatic test_zero_refs();
        default_knobs();
        begin_load(32'h3000, 3'd0);
        finish_load("zero", 200);
        total += 3;
        if (rd_q.size() != 0) begin bad++; $display("FAIL zero_reads got=%0d exp=0", rd_q.size()); end
        if (done_cyc !== 9) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=9", done_cyc); end
        if (wa_q.size() != 8) begin bad++; $display("FAIL zero_wr_count got=%0d exp=8", wa_q.size()); end
        else for (int i = 0; i < 8; i++) begin
            total++;
            if (wa_q[i] !== 4'(i) || wd_q[i] !== 32'h0) begin
                bad++; $display("FAIL zero_wr[%0d] got=%h/%h exp=%h/0", i, wa_q[i], wd_q[i], 4'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        default_knobs();
        stall_req = 2; stall_left = 4;
        build_expected(32'h1000, 3);
        begin_load(32'h1000, 3'd3);
        finish_load("bp", 200);
        total += 3;
        if (done_cyc !== 28) begin bad++; $display("FAIL bp_done_cycle got=%0d exp=28", done_cyc); end
        if (addr_unstable !== 0) begin bad++; $display("FAIL bp_addr_stable got=%0d changes exp=0", addr_unstable); end
        if (stall_addr_q.size() != 4) begin bad++; $display("FAIL bp_stall_cycles got=%0d exp=4", stall_addr_q.size()); end
        else foreach (stall_addr_q[i]) begin
            total++;
            if (stall_addr_q[i] !== 32'h1004) begin bad++; $display("FAIL bp_stall_addr[%0d] got=%h exp=1004", i, stall_addr_q[i]); end
        end
        total++;
        if (wa_q.size() != exp_wa.size()) begin bad++; $display("FAIL bp_wr_count got=%0d exp=%0d", wa_q.size(), exp_wa.size()); end
        else foreach (exp_wa[i]) begin
            total++;
            if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
                bad++; $display("FAIL bp_wr[%0d] got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
            end
        end
    endtask

    task automatic test_ignored_inputs();
        default_knobs();
        mid_start_cyc = 5; spur_req = 2; spur_arm = 1'b1;
        build_expected(32'h1000, 3);
        begin_load(32'h1000, 3'd3);
        finish_load("ign", 200);
        total += 4;
        if (done_cyc !== 25) begin bad++; $display("FAIL ign_done_cycle got=%0d exp=25", done_cyc); end
        if (done_cnt !== 1) begin bad++; $display("FAIL ign_done_pulses got=%0d exp=1", done_cnt); end
        if (refs_glitch !== 0) begin bad++; $display("FAIL ign_refs_stable got=%0d changes exp=0", refs_glitch); end
        if (tbl_phase_refs_o !== 3'd3) begin bad++; $display("FAIL ign_refs_after got=%0d exp=3", tbl_phase_refs_o); end
        total++;
        if (wa_q.size() != exp_wa.size()) begin bad++; $display("FAIL ign_wr_count got=%0d exp=%0d", wa_q.size(), exp_wa.size()); end
        else foreach (exp_wa[i]) begin
            total++;
            if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
                bad++; $display("FAIL ign_wr[%0d] got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
            end
        end
        repeat (3) tick();
        total++;
        if (busy_o !== 1'b0 || done_cnt !== 1) begin
            bad++; $display("FAIL ign_no_restart got=busy %b done %0d exp=busy 0 done 1", busy_o, done_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        default_knobs();
        begin_load(32'h1000, 3'd3);
        while (cyc < 19) tick();
        resetn_i = 1'b0;
        tick();
        total += 3;
        if ({busy_o, done_o, mem_req_o, tbl_wren_o} !== 4'b0000) begin
            bad++; $display("FAIL rstmid_strobes got=%b exp=0000", {busy_o, done_o, mem_req_o, tbl_wren_o});
        end
        if (tbl_phase_refs_o !== 3'd0) begin bad++; $display("FAIL rstmid_refs got=%0d exp=0", tbl_phase_refs_o); end
        if (wa_q.size() != 9) begin bad++; $display("FAIL rstmid_partial_writes got=%0d exp=9", wa_q.size()); end
        resetn_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        total++;
        if ({busy_o, mem_req_o, tbl_wren_o} !== 3'b000) begin
            bad++; $display("FAIL rstmid_late_rvalid got=%b exp=000", {busy_o, mem_req_o, tbl_wren_o});
        end
        build_expected(32'h2000, 2);
        begin_load(32'h2000, 3'd2);
        finish_load("rstmid", 200);
        total += 2;
        if (done_cyc !== 19) begin bad++; $display("FAIL rstmid_done_cycle got=%0d exp=19", done_cyc); end
        if (rd_q.size() != exp_rd.size()) begin bad++; $display("FAIL rstmid_rd_count got=%0d exp=%0d", rd_q.size(), exp_rd.size()); end
        else foreach (exp_rd[i]) begin
            total++;
            if (rd_q[i] !== exp_rd[i]) begin bad++; $display("FAIL rstmid_rd[%0d] got=%h exp=%h", i, rd_q[i], exp_rd[i]); end
        end
        total++;
        if (wa_q.size() != exp_wa.size()) begin bad++; $display("FAIL rstmid_wr_count got=%0d exp=%0d", wa_q.size(), exp_wa.size()); end
        else foreach (exp_wa[i]) begin
            total++;
            if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
                bad++; $display("FAIL rstmid_wr[%0d] got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] hand_rd [6];
        hand_rd = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0018, 32'h0000_001C, 32'h0000_0020};
        default_knobs();
        build_expected(32'hFFFF_FFF8, 3);
        begin_load(32'hFFFF_FFFB, 3'd3);
        finish_load("wrap", 200);
        total += 2;
        if (done_cyc !== 24) begin bad++; $display("FAIL wrap_done_cycle got=%0d exp=24", done_cyc); end
        if (rd_q.size() != 6) begin bad++; $display("FAIL wrap_rd_count got=%0d exp=6", rd_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            total++;
            if (rd_q[i] !== hand_rd[i]) begin bad++; $display("FAIL wrap_rd[%0d] got=%h exp=%h", i, rd_q[i], hand_rd[i]); end
        end
        total++;
        if (wa_q.size() != exp_wa.size()) begin bad++; $display("FAIL wrap_wr_count got=%0d exp=%0d", wa_q.size(), exp_wa.size()); end
        else foreach (exp_wa[i]) begin
            total++;
            if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
                bad++; $display("FAIL wrap_wr[%0d] got=%h/%h exp=%h/%h", i, wa_q[i], wd_q[i], exp_wa[i], exp_wd[i]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        cur_refs = '0;
        default_knobs();
        test_reset();
        test_basic();
        test_zero_refs();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid_load();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
